// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP socket-entry widths, flag indices and state encodings
package tcp_pkg;

  localparam int SEQ_W  = 32;
  localparam int SIZE_W = 16;
  localparam int FLAG_W = 8;

  localparam int FLAG_FIN = 7;
  localparam int FLAG_SYN = 6;
  localparam int FLAG_RST = 5;
  localparam int FLAG_PSH = 4;
  localparam int FLAG_ACK = 3;
  localparam int FLAG_URG = 2;
  localparam int FLAG_ECE = 1;
  localparam int FLAG_CWR = 0;

  localparam logic [FLAG_W-1:0] FLAGS_SYN_ACK = 8'h48;
  localparam logic [FLAG_W-1:0] FLAGS_ACK     = 8'h08;
  localparam logic [FLAG_W-1:0] FLAGS_FIN_ACK = 8'h88;

  typedef enum logic [2:0] {
    ST_CLOSED, ST_LISTEN, ST_SYN_PEND, ST_SYN_RCVD,
    ST_EST, ST_CLOSE_WAIT, ST_FIN_PEND, ST_LAST_ACK
  } tcp_state_e;

  // One-hot register encoding; bit position equals the binary state number.
  typedef enum logic [7:0] {
    OH_CLOSED     = 8'h01,
    OH_LISTEN     = 8'h02,
    OH_SYN_PEND   = 8'h04,
    OH_SYN_RCVD   = 8'h08,
    OH_EST        = 8'h10,
    OH_CLOSE_WAIT = 8'h20,
    OH_FIN_PEND   = 8'h40,
    OH_LAST_ACK   = 8'h80
  } tcp_oh_e;

  function automatic tcp_state_e oh_to_state(input logic [7:0] oh);
    tcp_state_e st;
    st = ST_CLOSED;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) st = tcp_state_e'(3'(i));
    end
    return st;
  endfunction

endpackage

// File: rtl/tcp_retx_timer.sv
// rtl/tcp_retx_timer.sv - retransmit timeout counter plus bounded retry counter
module tcp_retx_timer #(
  parameter int                   TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'd1000000,
  parameter int                   RETRY_MAX   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic retry_inc,
  input  logic retry_clr,
  output logic expire,
  output logic exhausted
);

  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_CYC - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] timer_q;
  logic [RW-1:0]        retry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      if (clear)       timer_q <= '0;
      else if (enable) timer_q <= timer_q + TIMEOUT_W'(1);
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + RW'(1);
    end
  end

  // Independent of clear: clear is derived from the next state, which depends on expire.
  assign expire    = enable && (timer_q == TIMER_LAST);
  assign exhausted = (retry_q >= RW'(RETRY_MAX));

endmodule

// File: rtl/tcp_passive_entry.sv
// rtl/tcp_passive_entry.sv - passive-open TCP socket entry: listen, SYN+ACK, establish, close
module tcp_passive_entry
  import tcp_pkg::*;
#(
  parameter int                   TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'd1000000,
  parameter int                   RETRY_MAX   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              listen_v_i,
  input  logic [SEQ_W-1:0]  init_seq_i,
  input  logic              close_v_i,
  input  logic              cancel_v_i,
  output logic              valid_o,
  output logic [2:0]        state_o,
  input  logic              rec_v_i,
  input  logic [SIZE_W-1:0] rec_size_i,
  input  logic [SEQ_W-1:0]  rec_seq_i,
  input  logic [SEQ_W-1:0]  rec_ack_i,
  input  logic [FLAG_W-1:0] rec_flag_i,
  input  logic              sent_v_i,
  input  logic [SIZE_W-1:0] send_size_i,
  output logic              force_send_v_o,
  output logic [FLAG_W-1:0] send_flag_o,
  output logic [SEQ_W-1:0]  send_seq_o,
  output logic [SEQ_W-1:0]  send_ack_o
);

  tcp_oh_e          state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d, ack_q, ack_d, isn_q, isn_d;
  logic             ack_pend_q, ack_pend_d;
  logic             tmr_expire, tmr_exhausted, retry_inc, retry_clr;

  logic rec_fin, rec_syn, rec_rst, rec_ack;
  assign rec_fin = rec_flag_i[FLAG_FIN];
  assign rec_syn = rec_flag_i[FLAG_SYN];
  assign rec_rst = rec_flag_i[FLAG_RST];
  assign rec_ack = rec_flag_i[FLAG_ACK];

  tcp_retx_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .RETRY_MAX  (RETRY_MAX)
  ) u_retx (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .enable   ((state_q == OH_SYN_RCVD) || (state_q == OH_LAST_ACK)),
    .retry_inc(retry_inc),
    .retry_clr(retry_clr),
    .expire   (tmr_expire),
    .exhausted(tmr_exhausted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OH_CLOSED;
      seq_q      <= '0;
      ack_q      <= '0;
      isn_q      <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      ack_q      <= ack_d;
      isn_q      <= isn_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    ack_d      = ack_q;
    isn_d      = isn_q;
    ack_pend_d = ack_pend_q;
    retry_inc  = 1'b0;
    if (cancel_v_i) begin
      state_d = OH_CLOSED;
    end else if (rec_v_i && rec_rst &&
                 ((state_q == OH_SYN_PEND) || (state_q == OH_SYN_RCVD))) begin
      state_d = OH_LISTEN;
    end else if (rec_v_i && rec_rst &&
                 ((state_q == OH_EST) || (state_q == OH_CLOSE_WAIT) ||
                  (state_q == OH_FIN_PEND) || (state_q == OH_LAST_ACK))) begin
      state_d = OH_CLOSED;
    end else begin
      unique case (state_q)
        OH_CLOSED: begin
          if (listen_v_i) begin
            state_d = OH_LISTEN;
            isn_d   = init_seq_i;
            seq_d   = init_seq_i;
          end
        end
        OH_LISTEN: begin
          if (rec_v_i && rec_syn && !rec_ack && !rec_rst) begin
            state_d = OH_SYN_PEND;
            ack_d   = rec_seq_i + SEQ_W'(1);
          end
        end
        OH_SYN_PEND: begin
          if (sent_v_i) begin
            state_d = OH_SYN_RCVD;
            seq_d   = isn_q + SEQ_W'(1);
          end
        end
        OH_SYN_RCVD: begin
          if (rec_v_i && rec_ack && (rec_ack_i == seq_q)) begin
            state_d    = OH_EST;
            ack_d      = ack_q + SEQ_W'(rec_size_i);
            ack_pend_d = (rec_size_i != '0);
          end else if (tmr_expire) begin
            state_d   = tmr_exhausted ? OH_LISTEN : OH_SYN_PEND;
            retry_inc = !tmr_exhausted;
          end
        end
        OH_EST, OH_CLOSE_WAIT: begin
          if (sent_v_i) begin
            seq_d      = seq_q + SEQ_W'(send_size_i);
            ack_pend_d = 1'b0;
          end
          // Any segment, even out of order, earns an ACK; set overrides the clear above.
          if (rec_v_i) begin
            ack_pend_d = 1'b1;
            if (rec_seq_i == ack_q) begin
              ack_d = ack_q + SEQ_W'(rec_size_i) + SEQ_W'(rec_fin);
              if (rec_fin && (state_q == OH_EST)) state_d = OH_CLOSE_WAIT;
            end
          end
          if (close_v_i) state_d = OH_FIN_PEND;
        end
        OH_FIN_PEND: begin
          if (sent_v_i) begin
            state_d    = OH_LAST_ACK;
            seq_d      = seq_q + SEQ_W'(1);
            ack_pend_d = 1'b0;
          end
        end
        OH_LAST_ACK: begin
          if (sent_v_i) ack_pend_d = 1'b0;
          if (rec_v_i && rec_ack && (rec_ack_i == seq_q)) begin
            state_d = OH_CLOSED;
          end else if (rec_v_i && rec_fin && (rec_seq_i == ack_q)) begin
            ack_d      = ack_q + SEQ_W'(rec_size_i) + SEQ_W'(1);
            ack_pend_d = 1'b1;
          end else if (tmr_expire) begin
            // Rewind over the FIN so the retransmitted FIN reuses its sequence number.
            state_d   = tmr_exhausted ? OH_CLOSED : OH_FIN_PEND;
            seq_d     = tmr_exhausted ? seq_q : seq_q - SEQ_W'(1);
            retry_inc = !tmr_exhausted;
          end
        end
        default: state_d = OH_CLOSED;
      endcase
    end
    if ((state_d == OH_CLOSED) || (state_d == OH_LISTEN)) ack_pend_d = 1'b0;
  end

  assign retry_clr = (state_d == OH_CLOSED) || (state_d == OH_LISTEN) ||
                     (state_d == OH_EST) || (state_d == OH_CLOSE_WAIT);

  always_comb begin
    force_send_v_o = 1'b0;
    send_flag_o    = '0;
    send_seq_o     = seq_q;
    unique case (state_q)
      OH_SYN_PEND: begin
        force_send_v_o = 1'b1;
        send_flag_o    = FLAGS_SYN_ACK;
        send_seq_o     = isn_q;
      end
      OH_SYN_RCVD: begin
        send_flag_o = FLAGS_SYN_ACK;
        send_seq_o  = isn_q;
      end
      OH_EST, OH_CLOSE_WAIT, OH_LAST_ACK: begin
        force_send_v_o = ack_pend_q;
        send_flag_o    = FLAGS_ACK;
      end
      OH_FIN_PEND: begin
        force_send_v_o = 1'b1;
        send_flag_o    = FLAGS_FIN_ACK;
      end
      default: send_flag_o = '0;
    endcase
  end

  assign send_ack_o = ack_q;
  assign valid_o    = (state_q == OH_EST) || (state_q == OH_CLOSE_WAIT);
  assign state_o    = oh_to_state(state_q);

  a_state_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(state_q));

endmodule
